// File: rtl/if_pc_stage.sv
// if_pc_stage: instruction-fetch PC register, next-PC select and interrupt entry/return FSM.
// Revision 1.0
`default_nettype none

module if_pc_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        eret,
  input  logic        int_req,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] IF_PC_out,
  output logic [31:0] IF_inst,
  output logic        IF_Flush,
  output logic        INT_detected,
  output logic        INT_restore,
  output logic [31:0] epc,
  output logic        int_active
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    INT_ENTER = 2'd1,
    HANDLER   = 2'd2,
    RESTORE   = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next, epc_next;
  logic [31:0] nextpc;
  logic        redirect;

  // Word-aligned next-PC selection; eret has the highest priority.
  always_comb begin
    nextpc = pc + 32'd4;
    if (eret)              nextpc = epc;
    else if (jr)           nextpc = jr_target;
    else if (jump)         nextpc = jump_target;
    else if (branch_taken) nextpc = branch_target;
    nextpc[1:0] = 2'b00;
  end

  assign redirect = eret | jr | jump | branch_taken;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    epc_next   = epc;
    IF_Flush   = 1'b0;
    case (state)
      RUN: begin
        if (PCWrite) begin
          if (int_req) begin
            // Save the PC that would have been fetched, keeping any redirect target.
            epc_next   = nextpc;
            pc_next    = INT_VECTOR;
            state_next = INT_ENTER;
          end else begin
            pc_next  = nextpc;
            IF_Flush = redirect;
          end
        end
      end
      INT_ENTER: state_next = HANDLER;
      HANDLER: begin
        if (PCWrite) begin
          pc_next  = nextpc;
          IF_Flush = redirect;
          if (eret) state_next = RESTORE;
        end
      end
      RESTORE: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc    <= {RESET_PC[31:2], 2'b00};
      epc   <= 32'd0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      epc   <= epc_next;
    end
  end

  assign imem_addr    = pc;
  assign IF_PC_out    = pc;
  assign IF_inst      = imem_rdata;
  assign INT_detected = (state == INT_ENTER);
  assign INT_restore  = (state == RESTORE);
  assign int_active   = (state != RUN);

endmodule

`default_nettype wire

// File: doc/if_pc_stage.md
Name: if_pc_stage

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. Holds the PC and selects the next PC from sequential, branch, jump, jr and eret sources. Drives the instruction-memory address and presents {IF_inst, IF_PC_out} to IF/ID. Owns the interrupt entry/return FSM and generates IF_Flush, INT_detected and INT_restore, which IF/ID consumes.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset
INT_VECTOR, 32'h0000_4180, handler entry address

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
PCWrite  input  1  0 = stall from the hazard unit; PC and FSM hold
branch_taken  input  1  branch resolved taken in ID
branch_target  input  32  branch destination
jump  input  1  j/jal in ID
jump_target  input  32  jump destination
jr  input  1  jr/jalr in ID
jr_target  input  32  register destination
eret  input  1  eret decoded in ID
int_req  input  1  level-sensitive external interrupt request
imem_rdata  input  32  asynchronous instruction-memory read data
imem_addr  output  32  equals pc
IF_PC_out  output  32  address of the fetched instruction (equals pc)
IF_inst  output  32  imem_rdata passed through combinationally
IF_Flush  output  1  squash IF/ID on the next edge
INT_detected  output  1  IF/ID backs up and holds (one cycle)
INT_restore  output  1  IF/ID restores its backup (one cycle)
epc  output  32  saved return PC
int_active  output  1  1 when state != RUN

Behaviour:
- Reset (asynchronous, any state): pc=RESET_PC, epc=0, state=RUN. IF_Flush, INT_detected, INT_restore and int_active are all 0.
- pc[1:0] is always 2'b00; bits [1:0] of every target are ignored. pc+4 wraps modulo 2^32.
- nextpc priority: eret > jr > jump > branch_taken > pc+4.
- FSM states: RUN, INT_ENTER, HANDLER, RESTORE.
- RUN, PCWrite=1, int_req=0: pc<=nextpc. IF_Flush=1 when any redirect (eret, jr, jump or branch_taken) is selected.
- RUN, PCWrite=1, int_req=1:
  - epc<=nextpc, so a simultaneous redirect target is preserved.
  - pc<=INT_VECTOR; state<=INT_ENTER.
  - IF_Flush=0.
- PCWrite=0 in RUN or HANDLER: pc, epc and state hold. IF_Flush=0, redirects are ignored, and int_req is not sampled.
- INT_ENTER (exactly one cycle, PCWrite ignored):
  - INT_detected=1; pc holds at INT_VECTOR.
  - state<=HANDLER.
- HANDLER: same next-PC and flush rules as RUN, but int_req is ignored (no nesting). When eret=1 and PCWrite=1: pc<=epc, IF_Flush=1, state<=RESTORE.
- RESTORE (exactly one cycle, PCWrite ignored):
  - INT_restore=1; pc holds at epc.
  - state<=RUN.
  - int_req is sampled again on the following cycle.
- eret in RUN is a plain redirect to epc with IF_Flush=1; no state change.
- INT_detected and INT_restore are Moore outputs decoded from state and never both 1. IF_Flush is combinational, from the current inputs and state.
- Latency: redirect inputs take effect at the next clock edge. imem_addr changes the same cycle pc changes.

Test Plan:
- Reset, then release with PCWrite=1 -> pc=3000 and increments 3004, 3008. Assert reset mid-run -> pc=3000 immediately, before any clock edge.
- At pc=3010: branch_taken=1, target=3100 -> IF_Flush=1 that cycle, next pc=3100. jr=1 and jump=1 together (jr_target=3200, jump_target=3300) -> pc=3200.
- PCWrite=0 for 3 cycles with jump=1 -> pc holds, IF_Flush=0. PCWrite=1 -> pc=jump_target.
- int_req=1 at pc=3020 -> epc=3024, pc=4180, INT_detected=1 for one cycle, pc holds 4180 one extra cycle, then 4184 in HANDLER. int_req held high in HANDLER -> no re-entry.
- eret in HANDLER -> IF_Flush=1, pc=3024, INT_restore=1 for one cycle, then RUN at 3028.
- int_req with branch_taken (target=3400) in the same cycle -> epc=3400. After eret, fetch resumes at 3400.
